pipeline_processor: RTL and testbench
=====================================

Name: pipeline_processor

Overview:
- 8-bit, 16-register, 4-stage (IF, ID, EX, WB) in-order pipelined processor core with 16-bit instructions.
- Harvard organisation: internal instruction memory, data memory and register file.
- The bench preloads these storage arrays hierarchically; the only ports are clock and reset.
- Full forwarding, so no stalls and no flushes are ever required.

Parameters:
- IMEM_DEPTH, 256, instruction words (16-bit); PC width = log2(IMEM_DEPTH).
- DMEM_DEPTH, 256, data bytes; address is 8 bits.
- NUM_REGS, 16, general registers (8-bit each).

Ports:
- clk  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).

Behaviour:
- Storage arrays are named exactly instr_mem[IMEM_DEPTH] (16b), reg_file[NUM_REGS] (8b) and data_mem[DMEM_DEPTH] (8b). They are hierarchically accessible.
- Reset never clears these arrays, so contents preloaded during reset survive.
- Reset clears the PC and all pipeline registers to 0, which is the NOP encoding. Effects are immediate (asynchronous).
- Encoding: [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2/imm4 (imm4 is zero-extended).
- Op 0 NOP: no effect.
- Op 1 ADD: rd = rs1 + rs2.
- Op 2 SUB: rd = rs1 - rs2.
- Op 3 LD: rd = data_mem[rs1 + imm4].
- Op 4 ST: data_mem[rs1 + imm4] = rd.
- Op 5 AND, Op 6 OR, Op 7 XOR: rd = rs1 op rs2.
- Ops 8-15 execute as NOP.
- Arithmetic is modulo 256; carries and borrows are discarded. Address sums are 8 bits and wrap.
- r0 is an ordinary writable register.
- IF: instr_mem[PC] is latched into IF/ID, then PC increments by 1. PC wraps from IMEM_DEPTH-1 to 0. There are no branches.
- ID: reads rs1, rs2 and rd (the store-data operand).
- Register-file bypass: if WB writes the same register in the same cycle, ID receives the WB value.
- EX: performs the ALU operation. Data memory is read combinationally for LD.
- ST writes data_mem on the rising edge that ends its EX cycle.
- EX/WB latches the result, rd and a write-enable. WE is set for ops 1, 2, 3, 5, 6, 7.
- WB: writes reg_file[rd] on the rising edge.
- Forwarding into EX: an operand equal to the EX/WB destination with WE=1 takes the EX/WB result. This priority applies to rs1, rs2 and ST data.
- Latency: the instruction fetched at edge k writes its register on edge k+3, and ST writes memory on edge k+2. Throughput is one instruction per cycle.
- Back-to-back ST then LD to the same address: LD returns the stored value.
- Reset asserted mid-run: in-flight instructions are discarded with no partial writes. Execution restarts from PC 0 after release.

Decomposition:
- Package proc_pkg holds:
  - opcode enum (OP_NOP, OP_ADD, OP_SUB, OP_LD, OP_ST, OP_AND, OP_OR, OP_XOR);
  - width constants (DATA_W=8, INSTR_W=16, REG_AW=4);
  - pipeline-register structs (if_id_t, id_ex_t, ex_wb_t).
- One natural sub-module: proc_alu, a combinational op/a/b -> result block.

Test Plan:
- Preload reg_file[2]=10, reg_file[3]=5, data_mem[10]=99, and program:
  - instr_mem[0]=0x1123 (ADD r1,r2,r3);
  - instr_mem[1]=0x2413 (SUB r4,r1,r3);
  - instr_mem[2]=0x3520 (LD r5,[r2+0]);
  - rest zero.
  Release reset -> r1=15 after edge 4, r4=10 after edge 5 (EX/WB forwarding), r5=99 after edge 6.
- Dependent instruction two slots after its producer (ADD r1; NOP; SUB r6,r1,r3) -> r6=10, proving the register-file write-through bypass.
- Overflow/underflow: r2=200, r3=100, ADD and SUB -> results 44 and 100. SUB r,r3,r2 -> 156.
- ST r2,[r7+3] with r7=5, followed immediately by LD r8,[r7+3] -> data_mem[8]=r2 and r8=r2.
- Reset asserted mid-program for half a cycle -> no further register/memory writes, PC=0. The program re-executes from instruction 0 after release.
- Opcodes 8-15 and AND/OR/XOR with r2=0xF0, r3=0x3C -> results 0x30, 0xFC, 0xCC. Undefined opcodes change nothing.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared types for the 4-stage pipeline: opcodes, widths and stage registers.
package proc_pkg;

   localparam int DATA_W  = 8;
   localparam int INSTR_W = 16;
   localparam int REG_AW  = 4;

   typedef enum logic [3:0] {
      OP_NOP = 4'd0,
      OP_ADD = 4'd1,
      OP_SUB = 4'd2,
      OP_LD  = 4'd3,
      OP_ST  = 4'd4,
      OP_AND = 4'd5,
      OP_OR  = 4'd6,
      OP_XOR = 4'd7
   } opcode_e;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
   } if_id_t;

   // b carries the zero-extended imm4 for LD/ST, otherwise the rs2 value.
   typedef struct packed {
      logic [3:0]        op;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] sd;
   } id_ex_t;

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [REG_AW-1:0] rd;
      logic              we;
   } ex_wb_t;

   function automatic logic writes_reg(input logic [3:0] op);
      return op inside {OP_ADD, OP_SUB, OP_LD, OP_AND, OP_OR, OP_XOR};
   endfunction

   function automatic logic uses_imm(input logic [3:0] op);
      return op inside {OP_LD, OP_ST};
   endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU; LD/ST reuse the adder for address generation.
module proc_alu
   import proc_pkg::*;
(
   input  logic [3:0]        op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] y_o
);

   always_comb begin
      y_o = '0;
      case (op_i)
         OP_ADD, OP_LD, OP_ST: y_o = a_i + b_i;
         OP_SUB:               y_o = a_i - b_i;
         OP_AND:               y_o = a_i & b_i;
         OP_OR:                y_o = a_i | b_i;
         OP_XOR:               y_o = a_i ^ b_i;
         default:              y_o = '0;
      endcase
   end

endmodule

// File: rtl/pipeline_processor.sv
// 8-bit, 16-register, IF/ID/EX/WB in-order core with full forwarding (never stalls).
module pipeline_processor
   import proc_pkg::*;
#(
   parameter int IMEM_DEPTH = 256,
   parameter int DMEM_DEPTH = 256,
   parameter int NUM_REGS   = 16
)
(
   input logic clk,
   input logic reset
);

   localparam int PC_W = $clog2(IMEM_DEPTH);

   logic [INSTR_W-1:0] instr_mem [IMEM_DEPTH];
   logic [DATA_W-1:0]  reg_file  [NUM_REGS];
   logic [DATA_W-1:0]  data_mem  [DMEM_DEPTH];

   logic [PC_W-1:0] pc_q, pc_d;
   if_id_t          if_id_q, if_id_d;
   id_ex_t          id_ex_q, id_ex_d;
   ex_wb_t          ex_wb_q, ex_wb_d;

   logic [3:0]        id_op;
   logic [REG_AW-1:0] id_rd, id_rs1, id_rs2;
   logic [DATA_W-1:0] rf_rs1, rf_rs2, rf_rd;
   logic [DATA_W-1:0] ex_a, ex_b, ex_sd, alu_y;

   assign pc_d         = (pc_q == PC_W'(IMEM_DEPTH-1)) ? '0 : pc_q + 1'b1;
   assign if_id_d.instr = instr_mem[pc_q];

   assign id_op  = if_id_q.instr[15:12];
   assign id_rd  = if_id_q.instr[11:8];
   assign id_rs1 = if_id_q.instr[7:4];
   assign id_rs2 = if_id_q.instr[3:0];

   // Write-through: a register being written by WB this cycle is seen by ID.
   always_comb begin
      rf_rs1 = reg_file[id_rs1];
      rf_rs2 = reg_file[id_rs2];
      rf_rd  = reg_file[id_rd];
      if (ex_wb_q.we && ex_wb_q.rd == id_rs1) rf_rs1 = ex_wb_q.result;
      if (ex_wb_q.we && ex_wb_q.rd == id_rs2) rf_rs2 = ex_wb_q.result;
      if (ex_wb_q.we && ex_wb_q.rd == id_rd)  rf_rd  = ex_wb_q.result;
   end

   always_comb begin
      id_ex_d     = '0;
      id_ex_d.op  = id_op;
      id_ex_d.rd  = id_rd;
      id_ex_d.rs1 = id_rs1;
      id_ex_d.rs2 = id_rs2;
      id_ex_d.a   = rf_rs1;
      id_ex_d.b   = uses_imm(id_op) ? DATA_W'(id_rs2) : rf_rs2;
      id_ex_d.sd  = rf_rd;
   end

   always_comb begin
      ex_a  = id_ex_q.a;
      ex_b  = id_ex_q.b;
      ex_sd = id_ex_q.sd;
      if (ex_wb_q.we && ex_wb_q.rd == id_ex_q.rs1) ex_a = ex_wb_q.result;
      if (ex_wb_q.we && ex_wb_q.rd == id_ex_q.rs2 && !uses_imm(id_ex_q.op)) ex_b = ex_wb_q.result;
      if (ex_wb_q.we && ex_wb_q.rd == id_ex_q.rd)  ex_sd = ex_wb_q.result;
   end

   proc_alu u_alu (
      .op_i (id_ex_q.op),
      .a_i  (ex_a),
      .b_i  (ex_b),
      .y_o  (alu_y)
   );

   always_comb begin
      ex_wb_d        = '0;
      ex_wb_d.result = (id_ex_q.op == OP_LD) ? data_mem[alu_y] : alu_y;
      ex_wb_d.rd     = id_ex_q.rd;
      ex_wb_d.we     = writes_reg(id_ex_q.op);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q    <= '0;
         if_id_q <= '0;
         id_ex_q <= '0;
         ex_wb_q <= '0;
      end else begin
         pc_q    <= pc_d;
         if_id_q <= if_id_d;
         id_ex_q <= id_ex_d;
         ex_wb_q <= ex_wb_d;
      end
   end

   // Storage arrays are never reset; cleared stage registers already block writes.
   always_ff @(posedge clk) begin
      if (ex_wb_q.we) reg_file[ex_wb_q.rd] <= ex_wb_q.result;
   end

   always_ff @(posedge clk) begin
      if (id_ex_q.op == OP_ST) data_mem[alu_y] <= ex_sd;
   end

endmodule

// File: tb/tb_pipeline_processor.sv
// Directed-vector bench for pipeline_processor with hand-computed results.
module tb_pipeline_processor;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   pipeline_processor dut (
      .clk   (clk),
      .reset (reset)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Hold reset, wait for an edge under reset, then wipe all storage.
   task automatic setup();
      reset = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 256; i++) dut.instr_mem[i] = 16'h0000;
      for (int i = 0; i < 256; i++) dut.data_mem[i]  = 8'h00;
      for (int i = 0; i < 16; i++)  dut.reg_file[i]  = 8'h00;
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      // Test 1: latency and EX/WB forwarding
      $display("test 1: ADD/SUB/LD latency");
      setup();
      check("reset_pc", 16'(dut.pc_q), 16'h0);
      check("reset_we", 16'(dut.ex_wb_q.we), 16'h0);
      dut.reg_file[1]  = 8'hEE;
      dut.reg_file[2]  = 8'd10;
      dut.reg_file[3]  = 8'd5;
      dut.reg_file[4]  = 8'hEE;
      dut.data_mem[10] = 8'd99;
      dut.instr_mem[0] = 16'h1123;
      dut.instr_mem[1] = 16'h2413;
      dut.instr_mem[2] = 16'h3520;
      release_reset();
      tick(3);
      check("t1_r1_edge3", 16'(dut.reg_file[1]), 16'h00EE);
      tick(1);
      check("t1_r1_edge4", 16'(dut.reg_file[1]), 16'd15);
      check("t1_r4_edge4", 16'(dut.reg_file[4]), 16'h00EE);
      tick(1);
      check("t1_r4_edge5", 16'(dut.reg_file[4]), 16'd10);
      tick(1);
      check("t1_r5_edge6", 16'(dut.reg_file[5]), 16'd99);
      check("t1_pc_edge6", 16'(dut.pc_q), 16'd6);

      // Test 2: register-file write-through bypass
      $display("test 2: ADD; NOP; SUB dependent");
      setup();
      dut.reg_file[2]  = 8'd10;
      dut.reg_file[3]  = 8'd5;
      dut.instr_mem[0] = 16'h1123;
      dut.instr_mem[1] = 16'h0000;
      dut.instr_mem[2] = 16'h2613;
      release_reset();
      tick(7);
      check("t2_r1", 16'(dut.reg_file[1]), 16'd15);
      check("t2_r6", 16'(dut.reg_file[6]), 16'd10);

      // Test 3: modulo-256 wrap
      $display("test 3: overflow/underflow");
      setup();
      dut.reg_file[2]  = 8'd200;
      dut.reg_file[3]  = 8'd100;
      dut.instr_mem[0] = 16'h1123;
      dut.instr_mem[1] = 16'h2423;
      dut.instr_mem[2] = 16'h2532;
      release_reset();
      tick(7);
      check("t3_add_ovf", 16'(dut.reg_file[1]), 16'd44);
      check("t3_sub", 16'(dut.reg_file[4]), 16'd100);
      check("t3_sub_unf", 16'(dut.reg_file[5]), 16'd156);

      // Test 4: ST then LD same address, plus forwarded store data
      $display("test 4: ST/LD back-to-back");
      setup();
      dut.reg_file[2]  = 8'h77;
      dut.reg_file[7]  = 8'd5;
      dut.instr_mem[0] = 16'h4273;
      dut.instr_mem[1] = 16'h3873;
      dut.instr_mem[2] = 16'h1977;
      dut.instr_mem[3] = 16'h4974;
      release_reset();
      tick(8);
      check("t4_dm8", 16'(dut.data_mem[8]), 16'h0077);
      check("t4_r8", 16'(dut.reg_file[8]), 16'h0077);
      check("t4_r9", 16'(dut.reg_file[9]), 16'd10);
      check("t4_dm9_fwd", 16'(dut.data_mem[9]), 16'd10);

      // Test 5: asynchronous reset mid-program
      $display("test 5: mid-run reset");
      setup();
      dut.reg_file[2]  = 8'd1;
      dut.reg_file[3]  = 8'd2;
      dut.reg_file[4]  = 8'hAA;
      dut.reg_file[5]  = 8'hBB;
      dut.reg_file[6]  = 8'hCC;
      dut.data_mem[9]  = 8'h55;
      dut.instr_mem[0] = 16'h1423;
      dut.instr_mem[1] = 16'h1522;
      dut.instr_mem[2] = 16'h4209;
      dut.instr_mem[3] = 16'h1633;
      release_reset();
      tick(3);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("t5_pc_async", 16'(dut.pc_q), 16'h0);
      check("t5_we_async", 16'(dut.ex_wb_q.we), 16'h0);
      #3;
      reset = 1'b1;
      tick(1);
      check("t5_r4_discard", 16'(dut.reg_file[4]), 16'h00AA);
      check("t5_pc_restart", 16'(dut.pc_q), 16'd1);
      tick(2);
      check("t5_r4_pending", 16'(dut.reg_file[4]), 16'h00AA);
      check("t5_dm9_pending", 16'(dut.data_mem[9]), 16'h0055);
      tick(1);
      check("t5_r4", 16'(dut.reg_file[4]), 16'd3);
      tick(4);
      check("t5_r5", 16'(dut.reg_file[5]), 16'd2);
      check("t5_dm9", 16'(dut.data_mem[9]), 16'd1);
      check("t5_r6", 16'(dut.reg_file[6]), 16'd4);

      // Test 6: logic ops, r0 writes, undefined opcodes
      $display("test 6: AND/OR/XOR and ops 8-15");
      setup();
      dut.reg_file[2]  = 8'hF0;
      dut.reg_file[3]  = 8'h3C;
      dut.reg_file[9]  = 8'h11;
      dut.reg_file[10] = 8'h22;
      dut.instr_mem[0] = 16'h5123;
      dut.instr_mem[1] = 16'h6423;
      dut.instr_mem[2] = 16'h7523;
      dut.instr_mem[3] = 16'h8923;
      dut.instr_mem[4] = 16'hFA23;
      dut.instr_mem[5] = 16'h1023;
      release_reset();
      tick(10);
      check("t6_and", 16'(dut.reg_file[1]), 16'h0030);
      check("t6_or", 16'(dut.reg_file[4]), 16'h00FC);
      check("t6_xor", 16'(dut.reg_file[5]), 16'h00CC);
      check("t6_op8", 16'(dut.reg_file[9]), 16'h0011);
      check("t6_op15", 16'(dut.reg_file[10]), 16'h0022);
      check("t6_r0", 16'(dut.reg_file[0]), 16'h002C);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
